// File: rtl/x_dl_edge_reader.sv
// Delay-line edge launcher and capture decoder: fires one rising edge, snapshots the taps,
// then counts ones and flags non-thermometer captures chunk by chunk.
module x_dl_edge_reader #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned CHUNK   = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned RECOVER = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_dl,
    input  logic [WIDTH-1:0] i_taps,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_count,
    output logic             o_bubble
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SET_W  = $clog2(SETTLE + 1);
    localparam int unsigned REC_W  = $clog2(RECOVER + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StCapture,
        StDecode,
        StHold
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [IDX_W-1:0] r_idx;
    logic [SET_W-1:0] r_settle;
    logic [REC_W-1:0] r_rec;
    logic [CNT_W-1:0] r_acc;
    logic             r_seen_zero;
    logic             r_bub_acc;

    logic [CHUNK-1:0] w_chunk;
    logic [CNT_W-1:0] w_pop;
    logic             w_seen;
    logic             w_bub;

    assign w_chunk = r_shadow[int'(r_idx) * CHUNK +: CHUNK];

    // Scan upward: any 1 found after a 0 (possibly in an earlier chunk) is a bubble.
    always_comb begin
        w_pop  = '0;
        w_seen = r_seen_zero;
        w_bub  = r_bub_acc;
        for (int j = 0; j < CHUNK; j++) begin
            if (w_chunk[j]) begin
                w_pop = w_pop + CNT_W'(1);
                if (w_seen) begin
                    w_bub = 1'b1;
                end
            end else begin
                w_seen = 1'b1;
            end
        end
    end

    assign o_busy = (r_state != StIdle) || (r_rec != '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= StIdle;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_settle    <= '0;
            r_rec       <= '0;
            r_acc       <= '0;
            r_seen_zero <= 1'b0;
            r_bub_acc   <= 1'b0;
            o_dl        <= 1'b0;
            o_valid     <= 1'b0;
            o_count     <= '0;
            o_bubble    <= 1'b0;
        end else begin
            // Free-running recovery countdown; the capture branch below reloads it.
            if (r_rec != '0) begin
                r_rec <= r_rec - REC_W'(1);
            end
            case (r_state)
                StIdle: begin
                    if (i_start && (r_rec == '0)) begin
                        r_state  <= StLaunch;
                        r_settle <= '0;
                    end
                end
                StLaunch: begin
                    o_dl <= 1'b1;
                    if (r_settle == SET_W'(SETTLE - 1)) begin
                        r_state <= StCapture;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                StCapture: begin
                    r_shadow    <= i_taps;
                    o_dl        <= 1'b0;
                    r_rec       <= REC_W'(RECOVER);
                    r_acc       <= '0;
                    r_seen_zero <= 1'b0;
                    r_bub_acc   <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= StDecode;
                end
                StDecode: begin
                    r_acc       <= r_acc + w_pop;
                    r_seen_zero <= w_seen;
                    r_bub_acc   <= w_bub;
                    r_idx       <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(NCHUNK - 1)) begin
                        o_count  <= r_acc + w_pop;
                        o_bubble <= w_bub;
                        o_valid  <= 1'b1;
                        r_state  <= StHold;
                    end
                end
                StHold: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_x_dl_edge_reader.sv
// Directed bench for x_dl_edge_reader: default instance plus a RECOVER=30 instance.
module tb_x_dl_edge_reader;

    localparam int unsigned W = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_taps = '0;
    logic         o_busy, o_dl, o_valid, o_bubble;
    logic [7:0]   o_count;

    logic         r_start = 1'b0;
    logic         r_ready = 1'b0;
    logic [W-1:0] r_taps = '0;
    logic         rb_busy, rb_dl, rb_valid, rb_bubble;
    logic [7:0]   rb_count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    x_dl_edge_reader u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_dl    (o_dl),
        .i_taps  (i_taps),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_count (o_count),
        .o_bubble(o_bubble)
    );

    x_dl_edge_reader #(.RECOVER(30)) u_rec (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (r_start),
        .o_busy  (rb_busy),
        .o_dl    (rb_dl),
        .i_taps  (r_taps),
        .o_valid (rb_valid),
        .i_ready (r_ready),
        .o_count (rb_count),
        .o_bubble(rb_bubble)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start sampled at edge k; expects o_dl high after k+1,k+2 and o_valid after k+19.
    task automatic run_meas(input logic [W-1:0] taps, input int exp_cnt, input logic exp_bub,
                            input int hold, input bit early_ready);
        i_taps  = taps;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        chk("busy_on_accept", o_busy, 1);
        chk("dl_at_k", o_dl, 0);
        step;
        chk("dl_at_k1", o_dl, 1);
        step;
        chk("dl_at_k2", o_dl, 1);
        step;
        chk("dl_at_capture", o_dl, 0);
        repeat (15) step;
        chk("valid_not_early", o_valid, 0);
        if (early_ready) i_ready = 1'b1;
        step;
        chk("valid_at_k19", o_valid, 1);
        chk("count", o_count, exp_cnt);
        chk("bubble", o_bubble, exp_bub);
        for (int h = 0; h < hold; h++) begin
            i_taps  = ~i_taps;
            i_start = ~i_start;
            step;
            chk("hold_valid", o_valid, 1);
            chk("hold_count", o_count, exp_cnt);
            chk("hold_bubble", o_bubble, exp_bub);
            chk("hold_no_launch", o_dl, 0);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        step;
        i_ready = 1'b0;
        chk("valid_dropped", o_valid, 0);
        chk("busy_after_xfer", o_busy, 0);
        chk("count_kept", o_count, exp_cnt);
        chk("bubble_kept", o_bubble, exp_bub);
    endtask

    initial begin
        logic [W-1:0] v;

        repeat (3) step;
        chk("rst_dl", o_dl, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_bubble", o_bubble, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b1;
        step;

        run_meas('0, 0, 1'b0, 0, 1'b0);
        v = (W'(1) << 40) - W'(1);
        run_meas(v, 40, 1'b0, 0, 1'b0);
        run_meas('1, 128, 1'b0, 0, 1'b0);
        v = W'(32'h0010_000F);
        run_meas(v, 5, 1'b1, 0, 1'b0);
        v = W'(1) << 127;
        run_meas(v, 1, 1'b1, 0, 1'b0);
        run_meas(W'(7), 3, 1'b0, 6, 1'b0);
        v = W'(32'h0000_0F00);
        run_meas(v, 4, 1'b1, 0, 1'b1);

        // Recovery instance: capture at edge k+3 loads 30, so the earliest accept is k+34.
        r_taps  = W'(3);
        r_start = 1'b1;
        step;
        r_start = 1'b0;
        repeat (2) step;
        chk("rec_dl_high", rb_dl, 1);
        step;
        chk("rec_dl_capture", rb_dl, 0);
        repeat (16) step;
        chk("rec_valid", rb_valid, 1);
        chk("rec_count", rb_count, 2);
        r_ready = 1'b1;
        step;
        r_ready = 1'b0;
        r_start = 1'b1;
        chk("rec_valid_drop", rb_valid, 0);
        chk("rec_busy_recovering", rb_busy, 1);
        for (int e = 21; e <= 34; e++) begin
            step;
            chk("rec_dl_gap", rb_dl, 0);
            if (e == 32) chk("rec_busy_k32", rb_busy, 1);
            if (e == 33) chk("rec_busy_k33", rb_busy, 0);
        end
        step;
        r_start = 1'b0;
        chk("rec_relaunch", rb_dl, 1);
        repeat (25) step;
        r_ready = 1'b1;
        step;
        r_ready = 1'b0;
        repeat (35) step;

        // Reset mid-launch: o_dl must fall without waiting for a clock.
        i_taps  = '1;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        step;
        chk("pre_rst_dl", o_dl, 1);
        rst = 1'b0;
        #1;
        chk("rst_launch_dl", o_dl, 0);
        chk("rst_launch_busy", o_busy, 0);
        step;
        rst = 1'b1;
        step;

        // Reset during DECODE.
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        repeat (8) step;
        chk("pre_rst_busy", o_busy, 1);
        rst = 1'b0;
        #1;
        chk("rst_dec_dl", o_dl, 0);
        chk("rst_dec_valid", o_valid, 0);
        chk("rst_dec_count", o_count, 0);
        chk("rst_dec_bubble", o_bubble, 0);
        chk("rst_dec_busy", o_busy, 0);
        step;
        rst = 1'b1;
        step;
        chk("post_rst_busy", o_busy, 0);
        v = (W'(1) << 40) - W'(1);
        run_meas(v, 40, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/x_dl_edge_reader.md
Name: x_dl_edge_reader

Overview:
Measurement controller at the far end of a tapped delay line. It launches a single rising edge into the line and captures the registered tap word once. It then decodes the capture over several cycles into a tap count and a bubble flag, and hands the result to the host-side register logic with a valid/ready handshake. It sits between the UART register bridge (start/result) and the delay line instance (`o_dl` drives the line input, `i_taps` is the line's registered output).

Parameters:
- WIDTH, 128, number of delay line taps; must be a multiple of CHUNK.
- CHUNK, 8, taps decoded per clock in DECODE.
- CNT_W, 8, width of `o_count`; must satisfy 2^CNT_W > WIDTH.
- SETTLE, 2, cycles `o_dl` is held high before capture; minimum 1.
- RECOVER, 4, minimum cycles `o_dl` stays low after capture before the next launch; minimum 1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_start  in  1  request one measurement; sampled only when `o_busy`=0.
- o_busy  out  1  high from the accepted start until the next start can be accepted.
- o_dl  out  1  edge launched into the delay line input.
- i_taps  in  WIDTH  registered tap snapshot from the delay line; bit 0 is the first tap.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts result.
- o_count  out  CNT_W  number of ones in the captured tap word.
- o_bubble  out  1  capture was not a clean thermometer code.

Behaviour:
- Reset (i_rst=0, async):
  - state=IDLE.
  - `o_dl`, `o_valid`, `o_count`, `o_bubble` and `o_busy` all 0.
  - Shadow register, chunk index and recovery counter all 0.
  - Applies mid-operation with no partial result; `o_dl` falls immediately.
- States: IDLE, LAUNCH, CAPTURE, DECODE, HOLD.
- IDLE:
  - Accept a start when `i_start`=1 and the recovery counter is 0; go to LAUNCH.
  - `i_start` in any other state, or with the recovery counter nonzero, is ignored. No queuing.
- LAUNCH:
  - `o_dl`=1 from the edge after acceptance.
  - Stay SETTLE cycles, then go to CAPTURE.
- CAPTURE (one cycle):
  - Latch `i_taps` into the shadow register.
  - `o_dl`=0 from this edge.
  - Load the recovery counter with RECOVER.
  - Clear the accumulator and the seen-zero flag; chunk index = 0.
- DECODE (WIDTH/CHUNK cycles):
  - Each cycle processes shadow bits [idx*CHUNK +: CHUNK].
  - Accumulator += popcount(chunk).
  - Bubble is set if any 1 lies above a 0, scanning from bit 0 upward; the seen-zero flag carries across chunks.
  - `i_taps` changes during DECODE have no effect.
- Entering HOLD:
  - `o_count` and `o_bubble` load on the final DECODE edge.
  - `o_valid` goes to 1 on the same edge.
- HOLD:
  - `o_count` and `o_bubble` are stable while `o_valid`=1.
  - A transfer happens on an edge with `o_valid`=1 and `i_ready`=1. On that edge `o_valid`→0 and state→IDLE.
  - `o_count` and `o_bubble` keep their last value after transfer.
  - `i_ready` high before `o_valid` completes the transfer on the first HOLD edge.
- Recovery counter: decrements every cycle while nonzero, independent of state.
- `o_busy` = (state≠IDLE) OR (recovery counter≠0).
- Latency (defaults):
  - Start sampled at edge k → `o_dl` high for edges k+1..k+2.
  - Capture at edge k+3.
  - `o_valid` high after edge k+3+16 = k+19.
  - General form: `o_valid` after edge k+1+SETTLE+WIDTH/CHUNK.
- Width rule: all-ones capture gives `o_count`=WIDTH (128 fits in 8 bits). No saturation is needed.
- `o_bubble` definition: 0 exactly when the capture equals (2^n)−1 for some n in 0..WIDTH.

Test Plan:
- i_taps=0, pulse i_start → `o_dl` high exactly 2 cycles; `o_valid` at start+19; `o_count`=0, `o_bubble`=0.
- i_taps = lower 40 bits set → `o_count`=40, `o_bubble`=0; all-ones → `o_count`=128, `o_bubble`=0.
- i_taps = 0x0F plus bit 20 set → `o_count`=5, `o_bubble`=1; bit 127 only → `o_count`=1, `o_bubble`=1.
- Hold i_ready=0 for 6 cycles after `o_valid`, and toggle i_taps and i_start during that time:
  - Outputs stay stable and no new launch occurs.
  - i_ready=1 → `o_valid` drops next edge; `o_busy`=0.
- Build with RECOVER=30 and start again immediately after transfer:
  - The start is ignored until 30 cycles after capture.
  - `o_dl` low gap ≥ 30 cycles.
- Assert i_rst low during DECODE:
  - All outputs are 0 immediately.
  - After release, `o_busy`=0 and a new measurement produces the correct count.
